hilo_unit: RTL
==============

Name: hilo_unit

Overview:
- Downstream consumer of the ALU's double-width results. Latches the multiply/divide products (out1 -> LO, out2 -> HI) into the architectural HI/LO registers.
- Models multi-cycle multiply/divide latency with a busy counter and interlocks mfhi/mflo/mthi/mtlo against in-flight operations.
- Detects divide-by-zero (ALU o=1 and z=1 on a divide) and raises an exception pulse.

Parameters:
- WIDTH, 32, data width of HI, LO and all data ports.
- MUL_LAT, 4, cycles from mult/multu acceptance to HI/LO commit (>=1).
- DIV_LAT, 32, cycles from div/divu acceptance to HI/LO commit (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  mult/div result presented by ALU this cycle.
- op_div  in  1  1 = divide, 0 = multiply; sampled with start.
- alu_lo  in  WIDTH  ALU out1 (product low / quotient).
- alu_hi  in  WIDTH  ALU out2 (product high / remainder).
- alu_o  in  1  ALU overflow flag.
- alu_z  in  1  ALU zero flag.
- wr_en  in  1  mthi/mtlo request.
- wr_sel  in  1  0 = LO, 1 = HI.
- wr_data  in  WIDTH  mthi/mtlo data.
- rd_req  in  1  mfhi/mflo request.
- rd_sel  in  1  0 = LO, 1 = HI.
- flush  in  1  kill in-flight operation (pipeline exception).
- rd_data  out  WIDTH  selected HI or LO.
- rd_valid  out  1  rd_req & ~busy.
- busy  out  1  operation in flight.
- stall  out  1  busy & (start | rd_req | wr_en).
- div0_exc  out  1  one-cycle divide-by-zero pulse.

Behaviour:
- Reset (rst_n=0 at edge): HI=LO=0, state IDLE, count=0, pending regs 0, busy=0, div0_exc=0. Reset mid-BUSY aborts with no commit.
- States IDLE, BUSY. busy = (state==BUSY).
- IDLE, start=1, flush=0:
  - If op_div & alu_o & alu_z: stay IDLE, HI/LO unchanged, div0_exc=1 for the next cycle only.
  - Otherwise: capture alu_hi/alu_lo into pending, count <= (op_div ? DIV_LAT : MUL_LAT) - 1, go BUSY.
- BUSY, count!=0: count decrements each edge.
- BUSY, count==0: HI<=pending_hi, LO<=pending_lo, go IDLE. Start accepted at edge E0 commits at edge E0+LAT; busy is high for exactly LAT cycles.
- start while BUSY is ignored (not queued). stall asserts; upstream holds and replays.
- wr_en: accepted only when ~busy; writes the selected register at the edge. wr_en while busy is ignored and stall asserts.
- wr_en and start together in IDLE: both accepted. The write lands at E0; the start result overwrites both at E0+LAT.
- rd_data: combinational mux of current HI/LO by rd_sel. Valid only when rd_valid=1. Reads during busy must be retried.
- flush (synchronous, priority over everything except reset):
  - BUSY -> IDLE, pending discarded, no commit, including on the count==0 edge.
  - Same-cycle start ignored and div0_exc suppressed. Same-cycle wr_en ignored.
- Width: no arithmetic on data. count width is clog2(max(MUL_LAT,DIV_LAT)).

Optional Feature:
- Macro HILO_FWD_EN.
- Defined:
  - rd_data forwards wr_data when wr_en & ~busy & (wr_sel==rd_sel) in the same cycle.
  - On the commit cycle (BUSY, count==0, no flush), rd_valid=1 and rd_data returns the pending value, so reads need not wait the extra cycle.
- Undefined: rd_data always reflects the registered HI/LO. rd_valid is low throughout BUSY including the commit cycle.

Test Plan:
- Reset, then rd_req=1 rd_sel=0 and rd_sel=1 -> rd_valid=1, rd_data=0 both.
- start, op_div=0, alu_hi=32'h1, alu_lo=32'hFFFF_FFFE (MUL_LAT=4) -> busy high 4 cycles, HI=1, LO=FFFF_FFFE after 4th edge. rd_req during busy -> stall=1, rd_valid=0.
- start, op_div=1, alu_o=1, alu_z=1, with HI/LO preloaded 5/7 -> busy stays 0, div0_exc one-cycle pulse, HI=5, LO=7.
- div start (DIV_LAT=32), flush at cycle 10 -> busy drops next edge, HI/LO unchanged. Flush exactly on the count==0 cycle -> no commit.
- IDLE, wr_en=1 wr_sel=1 wr_data=32'hABCD and start in the same cycle (mult, hi=2, lo=3) -> HI=ABCD after E0, then HI=2, LO=3 after E0+MUL_LAT.
- HILO_FWD_EN on: wr_en LO=32'h55 with rd_req rd_sel=0 same cycle -> rd_data=55. Off -> rd_data=old LO.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO architectural register file with multi-cycle mult/div latency, interlocks and div-by-zero detect.
// Optional HILO_FWD_EN: forwards same-cycle mthi/mtlo data and the pending result on the commit cycle.
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic             alu_o,
  input  logic             alu_z,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic             rd_sel,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             stall,
  output logic             div0_exc
);

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] hi, hi_n, lo, lo_n;
  logic [WIDTH-1:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic             div0_n;
  logic             last_cycle;

  assign busy       = (state == BUSY);
  assign stall      = busy & (start | rd_req | wr_en);
  assign last_cycle = busy & (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      div0_exc <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      hi       <= hi_n;
      lo       <= lo_n;
      pend_hi  <= pend_hi_n;
      pend_lo  <= pend_lo_n;
      div0_exc <= div0_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    div0_n    = 1'b0;
    if (flush) begin
      // flush wins even on the commit edge; same-cycle start/write are dropped
      state_n = IDLE;
      count_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_en) begin
            if (wr_sel) hi_n = wr_data;
            else        lo_n = wr_data;
          end
          if (start) begin
            if (op_div && alu_o && alu_z) begin
              div0_n = 1'b1;
            end else begin
              pend_hi_n = alu_hi;
              pend_lo_n = alu_lo;
              count_n   = op_div ? DIV_CNT : MUL_CNT;
              state_n   = BUSY;
            end
          end
        end
        BUSY: begin
          if (last_cycle) begin
            hi_n    = pend_hi;
            lo_n    = pend_lo;
            state_n = IDLE;
          end else begin
            count_n = count - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef HILO_FWD_EN
  logic commit_now;
  assign commit_now = last_cycle & ~flush;
  assign rd_valid   = rd_req & (~busy | commit_now);

  always_comb begin
    rd_data = rd_sel ? hi : lo;
    if (commit_now)
      rd_data = rd_sel ? pend_hi : pend_lo;
    if (wr_en && !busy && (wr_sel == rd_sel))
      rd_data = wr_data;
  end
`else
  assign rd_valid = rd_req & ~busy;
  assign rd_data  = rd_sel ? hi : lo;
`endif

endmodule
